// File: rtl/nand_gate.sv
// nand_gate: bit-wise 2-input NAND with a registered copy of the result and
// a saturating count of enabled cycles in which any result bit is low.
// The output y is purely combinational and works with clk left idle.
// Optional feature macro: NAND_GATE_STICKY_EN adds the all_low_seen flag,
// which goes high once an enabled cycle sees y all zeros and holds until reset.
module nand_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] low_cnt
`ifdef NAND_GATE_STICKY_EN
  ,
  output logic             all_low_seen
`endif
);

  // Pure gate. A 0 on either input forces a 1 under the standard operator
  // semantics, and X/Z on the other inputs propagates as usual.
  assign y = ~(a & b);

  // The result has a low bit whenever it is not all ones.
  logic any_low;
  assign any_low = (y != {WIDTH{1'b1}});

  // The counter has reached its maximum and must hold there instead of wrapping.
  logic cnt_full;
  assign cnt_full = (low_cnt == {CNT_W{1'b1}});

  // Capture the registered NAND and the saturating low-bit count.
  // Reset takes priority over the enable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // in this block samples the values that existed before the clock edge.
    if (rst) begin
      y_q     <= {WIDTH{1'b1}};
      low_cnt <= '0;
    end else if (en) begin
      y_q <= y;
      if (any_low && !cnt_full) begin
        low_cnt <= low_cnt + CNT_W'(1);
      end
    end
  end

`ifdef NAND_GATE_STICKY_EN
  // Sticky flag. It sets on an enabled cycle where y is all zeros, which
  // means a and b are both all ones, and it clears only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_low_seen <= 1'b0;
    end else if (en && (y == {WIDTH{1'b0}})) begin
      all_low_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nand_gate.sv
// Self-checking bench for nand_gate.
// It checks the combinational truth table with the clock idle, then reset,
// latency, enable hold, saturation and the sticky-flag sequences. It finishes
// with randomized traffic checked against an arithmetic reference model.
module tb_nand_gate;

  int n_cmp  = 0;
  int n_fail = 0;

  logic clk    = 1'b0;
  logic clk_on = 1'b0;

  // The clock stays idle until clk_on is set, so the gate is first
  // exercised without any clock activity.
  always begin
    #5;
    if (clk_on) clk = ~clk;
  end

  // Instance 1: WIDTH=1, CNT_W=8
  logic       a1 = 1'b0, b1 = 1'b0, rst1 = 1'b0, en1 = 1'b0;
  logic       y1, yq1;
  logic [7:0] cnt1;
  // Instance 2: WIDTH=1, CNT_W=2 (saturation)
  logic       a2 = 1'b0, b2 = 1'b0, rst2 = 1'b0, en2 = 1'b0;
  logic       y2, yq2;
  logic [1:0] cnt2;
  // Instance 3: WIDTH=4, CNT_W=3 (random traffic and sticky flag)
  logic [3:0] a4 = '0, b4 = '0;
  logic       rst4 = 1'b0, en4 = 1'b0;
  logic [3:0] y4, yq4;
  logic [2:0] cnt4;
`ifdef NAND_GATE_STICKY_EN
  logic       sticky1, sticky2, sticky4;
`endif

  nand_gate #(.WIDTH(1), .CNT_W(8)) dut1 (
    .a(a1), .b(b1), .y(y1), .clk(clk), .rst(rst1), .en(en1),
    .y_q(yq1), .low_cnt(cnt1)
`ifdef NAND_GATE_STICKY_EN
    , .all_low_seen(sticky1)
`endif
  );

  nand_gate #(.WIDTH(1), .CNT_W(2)) dut2 (
    .a(a2), .b(b2), .y(y2), .clk(clk), .rst(rst2), .en(en2),
    .y_q(yq2), .low_cnt(cnt2)
`ifdef NAND_GATE_STICKY_EN
    , .all_low_seen(sticky2)
`endif
  );

  nand_gate #(.WIDTH(4), .CNT_W(3)) dut4 (
    .a(a4), .b(b4), .y(y4), .clk(clk), .rst(rst4), .en(en4),
    .y_q(yq4), .low_cnt(cnt4)
`ifdef NAND_GATE_STICKY_EN
    , .all_low_seen(sticky4)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for one rising edge, then move 1 ns past it. Outputs are sampled
  // there and inputs are changed there, both away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a;
    logic b;
    logic y;
  } comb_vec_t;

  typedef struct {
    logic       a;
    logic       b;
    logic       yq;
    logic [7:0] cnt;
  } seq_vec_t;

  comb_vec_t comb_tab[4];
  seq_vec_t  seq_tab[4];
  logic [1:0] sat_exp[6];

  // Reference model state for instance 3
  int m_yq, m_cnt, m_sticky;

  // Advance the model by one clock edge, using the inputs that are present
  // before that edge.
  function automatic void model_step(logic r, logic e, int a, int b);
    int conj;
    conj = a & b;
    if (r) begin
      m_yq = 15; m_cnt = 0; m_sticky = 0;
    end else if (e) begin
      m_yq = 15 - conj;
      if (conj != 0 && m_cnt < 7) m_cnt = m_cnt + 1;
      if (conj == 15) m_sticky = 1;
    end
  endfunction

  initial begin
    comb_tab[0] = '{1'b0, 1'b0, 1'b1};
    comb_tab[1] = '{1'b0, 1'b1, 1'b1};
    comb_tab[2] = '{1'b1, 1'b0, 1'b1};
    comb_tab[3] = '{1'b1, 1'b1, 1'b0};
    seq_tab[0]  = '{1'b0, 1'b0, 1'b1, 8'd0};
    seq_tab[1]  = '{1'b0, 1'b1, 1'b1, 8'd0};
    seq_tab[2]  = '{1'b1, 1'b0, 1'b1, 8'd0};
    seq_tab[3]  = '{1'b1, 1'b1, 1'b0, 8'd1};
    sat_exp     = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    // Combinational truth table with the clock idle
    for (int i = 0; i < 4; i++) begin
      a1 = comb_tab[i].a; b1 = comb_tab[i].b;
      #10;
      check($sformatf("comb_y[%0d]", i), 32'(y1), 32'(comb_tab[i].y));
    end

    // Start the clock and reset all three instances
    clk_on = 1'b1;
    a1 = 1'b1; b1 = 1'b1; en1 = 1'b1; rst1 = 1'b1;
    rst2 = 1'b1; rst4 = 1'b1;
    #1;
    check("y_during_reset", 32'(y1), 32'd0);
    tick();
    check("reset_y_q", 32'(yq1), 32'd1);
    check("reset_low_cnt", 32'(cnt1), 32'd0);
    check("y_still_comb_in_reset", 32'(y1), 32'd0);
    rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;

    // Registered latency: one edge per vector
    for (int i = 0; i < 4; i++) begin
      a1 = seq_tab[i].a; b1 = seq_tab[i].b;
      tick();
      check($sformatf("lat_y_q[%0d]", i), 32'(yq1), 32'(seq_tab[i].yq));
      check($sformatf("lat_cnt[%0d]", i), 32'(cnt1), 32'(seq_tab[i].cnt));
    end

    // Enable hold for 5 edges with a=b=1, then 2 edges with a=b=0
    en1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin a1 = 1'b0; b1 = 1'b0; end
      tick();
      check($sformatf("hold_y_q[%0d]", i), 32'(yq1), 32'd0);
      check($sformatf("hold_cnt[%0d]", i), 32'(cnt1), 32'd1);
    end
    en1 = 1'b1;
    tick();
    check("resume_y_q", 32'(yq1), 32'd1);
    check("resume_cnt", 32'(cnt1), 32'd1);
    a1 = 1'b1; b1 = 1'b1;
    tick();
    check("resume2_y_q", 32'(yq1), 32'd0);
    check("resume2_cnt", 32'(cnt1), 32'd2);

    // Reset while the enable is low still clears both registers
    en1 = 1'b0; rst1 = 1'b1;
    tick();
    check("midreset_y_q", 32'(yq1), 32'd1);
    check("midreset_cnt", 32'(cnt1), 32'd0);
    check("midreset_y", 32'(y1), 32'd0);
    rst1 = 1'b0;

    // Saturation with CNT_W=2
    a2 = 1'b1; b2 = 1'b1; en2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("sat_cnt[%0d]", i), 32'(cnt2), 32'(sat_exp[i]));
    end
    // A high result does not count, even when the counter is saturated
    a2 = 1'b0;
    tick();
    check("sat_hold_cnt", 32'(cnt2), 32'd3);
    check("sat_y_q", 32'(yq2), 32'd1);

    // Sticky sequence on the WIDTH=4 instance. Instance 3 has been idle since
    // its reset.
    m_yq = 15; m_cnt = 0; m_sticky = 0;
    a4 = 4'hF; b4 = 4'hF; en4 = 1'b1;
    #1;
    check("w4_y_allzero", 32'(y4), 32'h0);
    model_step(rst4, en4, int'(a4), int'(b4));
    tick();
    check("w4_yq_allzero", 32'(yq4), 32'h0);
    check("w4_cnt_a", 32'(cnt4), 32'd1);
`ifdef NAND_GATE_STICKY_EN
    check("sticky_set", 32'(sticky4), 32'd1);
`endif
    a4 = 4'h0; b4 = 4'h0;
    for (int i = 0; i < 3; i++) begin
      model_step(rst4, en4, int'(a4), int'(b4));
      tick();
`ifdef NAND_GATE_STICKY_EN
      check($sformatf("sticky_hold[%0d]", i), 32'(sticky4), 32'd1);
`endif
    end
    check("w4_cnt_b", 32'(cnt4), 32'd1);
    a4 = 4'hF; b4 = 4'h7;
    #1;
    check("w4_y_8", 32'(y4), 32'h8);
    model_step(rst4, en4, int'(a4), int'(b4));
    tick();
    check("w4_yq_8", 32'(yq4), 32'h8);
    check("w4_cnt_c", 32'(cnt4), 32'd2);
`ifdef NAND_GATE_STICKY_EN
    check("sticky_still", 32'(sticky4), 32'd1);
    rst4 = 1'b1;
    model_step(rst4, en4, int'(a4), int'(b4));
    tick();
    check("sticky_cleared", 32'(sticky4), 32'd0);
    rst4 = 1'b0;
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      a4   = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
      b4   = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
      en4  = ($urandom_range(3) != 0);
      rst4 = ($urandom_range(39) == 0);
      #1;
      check($sformatf("rnd_y[%0d]", i), 32'(y4), 32'(15 - (int'(a4) & int'(b4))));
      model_step(rst4, en4, int'(a4), int'(b4));
      tick();
      check($sformatf("rnd_yq[%0d]", i), 32'(yq4), 32'(m_yq));
      check($sformatf("rnd_cnt[%0d]", i), 32'(cnt4), 32'(m_cnt));
`ifdef NAND_GATE_STICKY_EN
      check($sformatf("rnd_sticky[%0d]", i), 32'(sticky4), 32'(m_sticky));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nand_gate.md
Name: nand_gate

Overview:
- Bit-wise 2-input NAND primitive for the basic-gates library.
- Combinational output y = ~(a & b) has zero latency and needs no clock, so the bare gate can be exercised stimulus-only.
- Adds a registered copy of y and a saturating count of cycles with any low output bit, for use in clocked datapaths and coverage monitors.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q.
- CNT_W, 8, width of low_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational NAND, ~(a & b).
- en  input  1  capture enable for y_q and low_cnt.
- y_q  output  WIDTH  registered NAND.
- low_cnt  output  CNT_W  saturating count of enabled cycles where y has at least one 0 bit.

Behaviour:
- Port declaration order is a, b, y, clk, rst, en, y_q, low_cnt. Positional a,b,y instantiation therefore binds the gate correctly.
- y:
  - Purely combinational: y[i] = ~(a[i] & b[i]) for every bit i.
  - Independent of clk, rst and en.
  - X/Z on an input bit propagates per standard operator semantics, except a 0 on either input forces 1.
- All registers update on the rising clk edge only. rst is sampled synchronously and has priority over en.
- Reset values:
  - y_q = all ones, which equals the NAND of 0,0.
  - low_cnt = 0.
- Capture (en=1, rst=0):
  - y_q <= ~(a & b). One-cycle latency from a/b to y_q.
  - If (~(a & b)) != all-ones, low_cnt increments by 1.
  - low_cnt saturates at 2^CNT_W-1 and holds there; no wrap.
- Hold (en=0, rst=0): y_q and low_cnt keep their values.
- Reset mid-operation: the next edge with rst=1 clears both registers regardless of en. Combinational y is unaffected.
- Undriven clk (pure combinational use): y must still be correct. y_q and low_cnt stay X/undefined, which is permitted.
- No internal state machine; no handshake beyond en.

Optional Feature:
- Macro: NAND_GATE_STICKY_EN.
- Defined:
  - Adds output port all_low_seen (1 bit), declared after low_cnt.
  - Reset value 0.
  - Set to 1 on any enabled cycle where y == all-zeros, meaning a and b are both all ones.
  - Stays 1 until the next reset.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Combinational truth table, WIDTH=1, no clock; apply each a,b pair for 10 ns:
  - 0,0 -> y=1
  - 0,1 -> y=1
  - 1,0 -> y=1
  - 1,1 -> y=0
- Reset: rst=1 for one edge with a=1, b=1, en=1 -> y_q=1, low_cnt=0. y=0 combinationally during reset.
- Registered latency: en=1, a,b stepped 00,01,10,11 on successive edges -> y_q one cycle later reads 1,1,1,0; low_cnt=1.
- Enable hold: en=0, a=1, b=1 for 5 edges -> y_q and low_cnt unchanged. Re-assert en -> updates resume next edge.
- Saturation: CNT_W=2, a=b=1, en=1 for 6 edges -> low_cnt goes 1,2,3,3,3,3.
- Sticky, WIDTH=4, NAND_GATE_STICKY_EN defined:
  - a=4'hF, b=4'hF for one enabled edge -> all_low_seen=1.
  - Then a=b=0 -> stays 1 until rst.
  - With a=4'hF, b=4'h7 -> y=4'h8; all_low_seen does not set; low_cnt increments.
